// File: rtl/controlador_tx_encoder.sv
// Transmit sequencer ahead of the 8b/10b encoder: buffers producer bytes and frames them as SOF/data/EOF with K28.5 fill.
// Outputs registered (SOF one edge after the IDLE decision); producer stalls on datos_listo=0 when the FIFO is full.
module controlador_tx_encoder #(
    parameter int PROFUNDIDAD = 4,
    parameter int N_SYNC      = 4,
    parameter int N_IDLE_MIN  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] datos_in,
    input  logic       datos_ultimo,
    input  logic       datos_valido,
    output logic       datos_listo,
    input  logic       habilitar,
    output logic [7:0] entradas,
    output logic       K,
    output logic       enb,
    output logic       ocupado,
    output logic       error_sub
);

    localparam int PW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(N_SYNC + 2);
    localparam int GW = $clog2(N_IDLE_MIN + 2);
    localparam logic [GW-1:0] GAP_MIN = GW'(N_IDLE_MIN);
    localparam logic [GW-1:0] GAP_MAX = '1;
    localparam logic [7:0]    K28_5   = 8'hBC;
    localparam logic [7:0]    K27_7   = 8'hFB;
    localparam logic [7:0]    K29_7   = 8'hFD;

    typedef enum logic [2:0] {
        ST_SYNC, ST_IDLE, ST_SOF, ST_DATOS, ST_EOF
    } estado_t;

    // state_q names what is on the outputs this cycle, not what is being decided
    estado_t         state_q, state_d;
    logic [SW-1:0]   sync_q, sync_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            last_q, last_d;

    logic [8:0]      mem_q [PROFUNDIDAD];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop, vacio;
    logic [8:0]      cabeza;

    logic [7:0]      dat_q, dat_d;
    logic            k_q, k_d, ocup_q, ocup_d, err_q, err_d, enb_q, listo_q, listo_d;

    assign push   = datos_valido & listo_q;
    assign vacio  = (cnt_q == '0);
    assign cabeza = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        listo_d = (cnt_d != CW'(PROFUNDIDAD));
    end

    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        gap_d   = gap_q;
        last_d  = 1'b0;
        pop     = 1'b0;
        dat_d   = K28_5;
        k_d     = 1'b1;
        ocup_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (sync_q == SW'(N_SYNC)) state_d = ST_IDLE;
                else                       sync_d  = sync_q + SW'(1);
            end
            ST_IDLE:  if (habilitar && !vacio && gap_q >= GAP_MIN) state_d = ST_SOF;
            ST_SOF:   state_d = ST_DATOS;
            ST_DATOS: if (last_q) state_d = ST_EOF;
            ST_EOF:   state_d = ST_IDLE;
            default:  state_d = ST_SYNC;
        endcase

        // outputs and side effects belong to the cycle being entered
        case (state_d)
            ST_SYNC: gap_d = GAP_MIN;
            ST_IDLE: if (gap_q != GAP_MAX) gap_d = gap_q + GW'(1);
            ST_SOF: begin
                dat_d  = K27_7;
                ocup_d = 1'b1;
            end
            ST_DATOS: begin
                ocup_d = 1'b1;
                if (!vacio) begin
                    pop    = 1'b1;
                    dat_d  = cabeza[7:0];
                    k_d    = 1'b0;
                    last_d = cabeza[8];
                end else begin
                    err_d  = 1'b1;
                end
            end
            ST_EOF: begin
                dat_d  = K29_7;
                ocup_d = 1'b1;
                gap_d  = '0;
            end
            default: gap_d = gap_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {datos_ultimo, datos_in};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_SYNC;
            sync_q   <= '0;
            gap_q    <= GAP_MIN;
            last_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dat_q    <= K28_5;
            k_q      <= 1'b1;
            ocup_q   <= 1'b0;
            err_q    <= 1'b0;
            enb_q    <= 1'b0;
            listo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            k_q      <= k_d;
            ocup_q   <= ocup_d;
            err_q    <= err_d;
            enb_q    <= 1'b1;
            listo_q  <= listo_d;
        end
    end

    assign entradas    = dat_q;
    assign K           = k_q;
    assign enb         = enb_q;
    assign ocupado     = ocup_q;
    assign error_sub   = err_q;
    assign datos_listo = listo_q;

endmodule

// File: doc/controlador_tx_encoder.md
Name: controlador_tx_encoder

Overview:
Transmit sequencer that drives the 8b/10b encoder (`entradas`/`K`/`enb`). It buffers bytes from an upstream producer in a small FIFO. It wraps each frame as SOF (K27.7), data bytes, then EOF (K29.7), and fills every other cycle with K28.5 commas. It sits directly in front of the encoder in the serial transmit path and owns the encoder's enable.

Parameters:
PROFUNDIDAD, 4, FIFO depth in bytes; power of 2, at least 2.
N_SYNC, 4, commas sent after reset release before any frame.
N_IDLE_MIN, 2, minimum commas between EOF and the next SOF.

Ports:
clk  in  1  single clock, posedge.
rst  in  1  reset; asynchronous, active-low.
datos_in  in  8  byte from producer.
datos_ultimo  in  1  marks `datos_in` as the last byte of its frame.
datos_valido  in  1  producer offers a byte.
datos_listo  out  1  FIFO can accept a byte (FIFO not full).
habilitar  in  1  permits a new frame to start.
entradas  out  8  byte to encoder.
K  out  1  control-character flag to encoder.
enb  out  1  encoder enable.
ocupado  out  1  high from SOF through EOF inclusive.
error_sub  out  1  underrun pulse.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - Outputs: `entradas`=8'hBC, `K`=1, `enb`=0, `datos_listo`=0, `ocupado`=0, `error_sub`=0.
  - FIFO emptied; counters cleared; state SYNC.
  - Reset asserted mid-frame aborts the frame; no EOF is sent.
- All outputs are registered and change only on posedge `clk`.
- FIFO:
  - Write when `datos_valido` & `datos_listo`; each entry stores 9 bits {ultimo, dato}.
  - `datos_listo` = !full, registered; it is 0 during reset and 1 from the first edge after release.
  - Offer while full: ignored; producer holds the byte.
  - Simultaneous push and pop: count unchanged. Pop of an empty FIFO never occurs.
  - Pointers wrap modulo PROFUNDIDAD.
- `enb`=1 from the first edge after reset release onward.
- States:
  - SYNC:
    - emit 8'hBC, K=1, for N_SYNC cycles, then go to IDLE;
    - idle-gap counter preset to N_IDLE_MIN.
  - IDLE:
    - emit 8'hBC, K=1; gap counter increments, saturating;
    - go to SOF when `habilitar` & FIFO non-empty & gap ≥ N_IDLE_MIN;
    - `habilitar`=0 keeps IDLE indefinitely.
  - SOF:
    - one cycle, emit 8'hFB, K=1, `ocupado`=1;
    - next state DATOS.
  - DATOS, FIFO non-empty:
    - pop the head byte; emit it with K=0;
    - if its ultimo bit is set, next state EOF, else stay.
  - DATOS, FIFO empty (underrun):
    - emit 8'hBC, K=1, and `error_sub`=1 for that cycle;
    - stay in DATOS; the frame resumes when data arrives.
  - EOF:
    - one cycle, emit 8'hFD, K=1, `ocupado`=1;
    - gap counter cleared; next state IDLE.
- `habilitar` deasserted mid-frame has no effect: the frame completes.
- `ocupado` is 1 in SOF, DATOS and EOF cycles, else 0.
- Latency: first byte written at edge t into an empty FIFO while IDLE with gap satisfied → SOF on `entradas` after edge t+1, that byte after edge t+2.
- A one-byte frame gives SOF, byte, EOF on consecutive cycles.

Test Plan:
- Reset and sync: hold `rst`=0 for 3 cycles, then release → `enb` 0→1; `entradas`=BC, K=1 for 4 cycles; `datos_listo`=1; `ocupado`=0.
- Single frame: after sync, write 8'h71, 8'h00, 8'h7F (ultimo on 7F) on consecutive cycles → `entradas` sequence FB(K1), 71, 00, 7F (K0), FD(K1), then BC; `ocupado` high for exactly 5 cycles.
- Back-to-back frames: queue frame {11} and frame {48}, both with ultimo → FB 11 FD BC BC FB 48 FD, i.e. exactly N_IDLE_MIN=2 commas between frames.
- FIFO full: hold `datos_valido`=1 for 6 cycles with `habilitar`=0 → `datos_listo` falls after the 4th write; only 4 bytes stored; set `habilitar`=1 → those 4 bytes sent in write order.
- Underrun: write 8'hAA (no ultimo), wait 3 cycles, then write 8'h55 with ultimo → FB AA BC BC … 55 FD; `error_sub` pulses on each BC inside the frame.
- Reset mid-frame: assert `rst` during DATOS → outputs immediately BC/K1/`enb`=0; FIFO empty; after release, SYNC restarts and no EOF is emitted.
